// File: rtl/sobel_frame_loader.sv
// Write side of the Sobel input frame buffer: stores one raster-order frame into
// input_memory, then holds start to sobel_exc until it reports finish.
module sobel_frame_loader #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 16,
  parameter int IMAGE_ROW_SIZE    = 128,
  parameter int IMAGE_COLUMN_SIZE = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  start_o,
  input  logic                  finish_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  // Handshake: a pixel transfers in any cycle where s_valid_i && s_ready_o are both
  // high at the rising edge; s_data_i/s_last_i are only looked at in such a cycle.

  localparam int N = IMAGE_ROW_SIZE * IMAGE_COLUMN_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_start;
  logic                  r_done;
  logic                  r_err;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_at_end;
  logic                  w_early;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign w_ready  = (r_state == LOAD) && rst_ni;
  assign w_accept = s_valid_i && w_ready;
  assign w_at_end = (r_cnt == LAST_ADDR);
  assign w_early  = s_last_i && !w_at_end;

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_accept && w_at_end) w_next = KICK;
      KICK:    w_next = RUN;
      RUN:     if (finish_i) w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_addr <= r_cnt;
        r_data <= s_data_i;
        // Counter restarts on both a short frame and a complete frame; it never wraps.
        if (w_early || w_at_end) r_cnt <= '0;
        else                     r_cnt <= r_cnt + 1'b1;
      end
      r_err   <= w_accept && (w_early || (w_at_end && !s_last_i));
      r_start <= (w_next == RUN);
      r_done  <= (r_state == RUN) && finish_i;
    end
  end

  assign s_ready_o    = w_ready;
  assign mem_wr_en_o  = r_wr_en;
  assign mem_addr_o   = r_addr;
  assign mem_data_o   = r_data;
  assign start_o      = r_start;
  assign busy_o       = (r_state != LOAD);
  assign frame_done_o = r_done;
  assign err_o        = r_err;

endmodule
